// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter among NUM_REQ byte streams.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BUSY_TIMEOUT = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 locked,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ASSERT, WAIT_IDLE} state_t;
  state_t state;
  logic [IW-1:0] ptr, cand, nxt_ptr;
  logic [IW:0] s;
  logic cand_ok, accept;
  logic [CW-1:0] cnt;
  // Scan from the highest offset down so the nearest valid requester after ptr wins.
  always_comb begin
    cand = grant_id;
    cand_ok = locked && req_valid[grant_id];
    s = '0;
    if (!locked)
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        s = {1'b0, ptr} + (IW+1)'(i);
        s = (s >= (IW+1)'(NUM_REQ)) ? s - (IW+1)'(NUM_REQ) : s;
        if (req_valid[s[IW-1:0]]) begin
          cand = s[IW-1:0];
          cand_ok = 1'b1;
        end
      end
  end
  assign accept = rst_n && state == IDLE && !tx_busy && cand_ok;
  assign req_ready = accept ? {{(NUM_REQ-1){1'b0}}, 1'b1} << cand : '0;
  assign nxt_ptr = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx_start <= 1'b0;
      tx_data <= '0;
      grant_id <= '0;
      locked <= 1'b0;
      timeout_err <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          tx_data <= req_data[{cand, 3'b000} +: 8];
          grant_id <= cand;
          locked <= !req_last[cand];
          ptr <= req_last[cand] ? nxt_ptr : ptr;
          tx_start <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT_ASSERT;
        end
        // Timeout lands on the BUSY_TIMEOUT-th cycle after the start pulse.
        WAIT_ASSERT: if (tx_busy) state <= WAIT_IDLE;
          else if (int'(cnt) + 2 >= BUSY_TIMEOUT) begin
            timeout_err <= 1'b1;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        WAIT_IDLE: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests against a cycle-level behavioural arbiter model plus literal checks.
module tb_uart_tx_arbiter;
  localparam int N = 4, BT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic tx_start, tx_busy = 1'b0, locked, timeout_err;
  logic [7:0] tx_data;
  logic [1:0] grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .locked(locked), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [8:0] q[N][$];
  int busy_mode = 0, byte_t = 3, busy_left = 0;
  int c = 0, free_from = 0, exp_start = -1, exp_to = -1, s_cyc = 0;
  int last_acc = -1, last_start = -1, last_to = -1, m_ptr = 0, m_gid = 0;
  bit watching = 0, rose = 0, m_lock = 0, mon_start = 0;
  logic [7:0] m_data = '0;
  logic [N-1:0] acc_mask = '0, last_mask = '0;
  logic [7:0] txlog[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Model: per-cycle expected outputs from arbitration rules and observed busy timing.
  always @(negedge clk) begin
    int cand;
    logic [N-1:0] er;
    c++;
    mon_start = tx_start;
    if (!rst_n) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_start", 32'(tx_start), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      m_ptr = 0; m_gid = 0; m_lock = 0; m_data = '0;
      free_from = 0; exp_start = -1; exp_to = -1; watching = 0; acc_mask = '0;
    end else begin
      cand = -1;
      if (c >= free_from && !tx_busy) begin
        if (m_lock) begin
          if (req_valid[m_gid]) cand = m_gid;
        end else
          for (int k = 0; k < N; k++)
            if (cand < 0 && req_valid[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
      end
      er = (cand < 0) ? '0 : N'(1) << cand;
      chk("ready", 32'(req_ready), 32'(er));
      chk("tx_start", 32'(tx_start), 32'(c == exp_start));
      chk("tx_data", 32'(tx_data), 32'(m_data));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("locked", 32'(locked), 32'(m_lock));
      chk("timeout_err", 32'(timeout_err), 32'(c == exp_to));
      if (req_ready != 0) begin last_acc = c; last_mask = req_ready; end
      if (tx_start) begin txlog.push_back(tx_data); last_start = c; end
      if (timeout_err) last_to = c;
      if (c == exp_start) begin
        s_cyc = c; rose = 0; watching = 1;
      end else if (watching) begin
        if (!rose) begin
          if (tx_busy) rose = 1;
          else if (c == s_cyc + BT - 1) begin exp_to = c + 1; free_from = c + 1; watching = 0; end
        end else if (!tx_busy) begin
          free_from = c + 1; watching = 0;
        end
      end
      if (cand >= 0) begin
        m_data = req_data[cand*8 +: 8];
        m_gid = cand;
        m_lock = !req_last[cand];
        if (req_last[cand]) m_ptr = (cand + 1) % N;
        exp_start = c + 1;
        free_from = 1 << 30;
      end
      acc_mask = req_ready & req_valid;
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = q[i].size() > 0;
      req_data[i*8 +: 8] = req_valid[i] ? q[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] ? q[i][0][8] : 1'b0;
    end
  endtask

  // Transmitter model: busy rises one cycle after start and lasts byte_t cycles.
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (acc_mask[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (mon_start && busy_mode == 0) busy_left = byte_t;
    tx_busy = busy_mode == 2 || (busy_mode == 0 && busy_left > 0);
    if (busy_left > 0) busy_left--;
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_tx(input int n, input string name);
    int k = 0;
    while (txlog.size() < n && k < 300) begin tick(); k++; end
    chk(name, 32'(txlog.size()), 32'(n));
  endtask

  initial begin
    int b, s1;
    logic [7:0] e2[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [7:0] e3[4] = '{8'h20, 8'h21, 8'h22, 8'h30};
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    // single byte, latency and pointer
    b = txlog.size();
    q[0].push_back({1'b1, 8'hA5});
    wait_tx(b + 1, "t1_wait");
    chk("t1_byte", 32'(txlog[b]), 32'h A5);
    chk("t1_latency", 32'(last_start - last_acc), 1);
    chk("t1_ready_mask", 32'(last_mask), 1);
    ticks(10);
    chk("t1_locked", 32'(locked), 0);
    chk("t1_grant", 32'(grant_id), 0);
    b = txlog.size();
    q[0].push_back({1'b1, 8'h50});
    q[1].push_back({1'b1, 8'h51});
    wait_tx(b + 2, "ptr_wait");
    chk("ptr_first", 32'(txlog[b]), 32'h51);
    chk("ptr_second", 32'(txlog[b+1]), 32'h50);
    ticks(10);
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    // rotation with all requesters valid
    b = txlog.size();
    q[0].push_back({1'b1, 8'h10}); q[0].push_back({1'b1, 8'h10});
    q[1].push_back({1'b1, 8'h11});
    q[2].push_back({1'b1, 8'h12});
    q[3].push_back({1'b1, 8'h13});
    wait_tx(b + 5, "t2_wait");
    for (int i = 0; i < 5; i++) chk("t2_order", 32'(txlog[b+i]), 32'(e2[i]));
    ticks(10);
    // locked multi-byte packet
    b = txlog.size();
    q[1].push_back({1'b0, 8'h20}); q[1].push_back({1'b0, 8'h21}); q[1].push_back({1'b1, 8'h22});
    q[2].push_back({1'b1, 8'h30});
    wait_tx(b + 1, "t3_w1");
    chk("t3_lock1", 32'(locked), 1);
    wait_tx(b + 2, "t3_w2");
    chk("t3_lock2", 32'(locked), 1);
    wait_tx(b + 3, "t3_w3");
    chk("t3_unlock", 32'(locked), 0);
    wait_tx(b + 4, "t3_w4");
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(txlog[b+i]), 32'(e3[i]));
    ticks(10);
    // busy never rises
    busy_mode = 1;
    tick();
    b = txlog.size();
    q[0].push_back({1'b1, 8'h60}); q[0].push_back({1'b1, 8'h61});
    wait_tx(b + 1, "t4_w1");
    s1 = last_start;
    wait_tx(b + 2, "t4_w2");
    chk("t4_timeout_at", 32'(last_to - s1), 32'(BT));
    chk("t4_next_accept", 32'(last_acc - s1), 32'(BT));
    chk("t4_byte2", 32'(txlog[b+1]), 32'h61);
    ticks(10);
    busy_mode = 0;
    ticks(3);
    // reset during a locked packet in WAIT_IDLE
    byte_t = 20;
    b = txlog.size();
    q[1].push_back({1'b0, 8'h70}); q[1].push_back({1'b1, 8'h71});
    wait_tx(b + 1, "t5_w1");
    ticks(3);
    chk("t5_pre_locked", 32'(locked), 1);
    chk("t5_pre_busy", 32'(tx_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_ready", 32'(req_ready), 0);
    chk("t5_start", 32'(tx_start), 0);
    chk("t5_data", 32'(tx_data), 0);
    chk("t5_grant", 32'(grant_id), 0);
    chk("t5_locked", 32'(locked), 0);
    chk("t5_to", 32'(timeout_err), 0);
    q[1].delete();
    q[0].push_back({1'b1, 8'h80});
    q[2].push_back({1'b1, 8'h82});
    ticks(2);
    rst_n = 1'b1;
    wait_tx(b + 3, "t5_w3");
    chk("t5_first", 32'(txlog[b+1]), 32'h80);
    chk("t5_second", 32'(txlog[b+2]), 32'h82);
    byte_t = 3;
    ticks(30);
    // busy held high while idle
    busy_mode = 2;
    tick();
    b = txlog.size();
    q[3].push_back({1'b1, 8'h40});
    ticks(6);
    chk("t6_ready", 32'(req_ready), 0);
    chk("t6_none", 32'(txlog.size()), 32'(b));
    busy_mode = 0;
    wait_tx(b + 1, "t6_wait");
    chk("t6_byte", 32'(txlog[b]), 32'h40);
    ticks(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
